// File: rtl/hack_reg_readout.sv
// hack_reg_readout
//   Bit-serial readout engine for Hack computer registers (A, D, PC, RAM words).
//   A start strobe snapshots a DATA_SIZE-wide word and shifts it out on an
//   SPI mode-0 style link: cs_n low for the frame, sclk idling low, sdo
//   changing only while sclk is low so the receiver samples on the sclk rise.
//
// Ports
//   clock      in   main clock, all logic on posedge
//   reset      in   synchronous active-high reset, wins over everything
//   vccd1/vssd1 inout supply pins, present only under USE_POWER_PINS
//   in         in   word to read out, sampled only when start is accepted
//   start      in   frame request, level-sampled while idle
//   busy       out  frame in progress (mirrors cs_n low)
//   done       out  one-cycle pulse as the frame completes
//   cs_n       out  frame select, active low
//   sclk       out  serial clock
//   sdo        out  serial data
//   dbg_state  out  current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
// Handshake: start is a level request; it is accepted on any edge where the
// engine is IDLE and is otherwise dropped, never queued. done pulses for one
// cycle in the cycle cs_n returns high.
module hack_reg_readout #(
  parameter int DATA_SIZE = 16,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                  vccd1,
  inout  wire                  vssd1,
`endif
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] in,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 sdo,
  output logic [1:0]           dbg_state
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_SIZE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sdo_q, sdo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // The shift register rotates rather than shifts, so the bit on sdo is
  // always the one at the outgoing end of the register.
  function automatic logic out_bit(input logic [DATA_SIZE-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_SIZE-1] : v[0];
  endfunction

  function automatic logic [DATA_SIZE-1:0] advance(input logic [DATA_SIZE-1:0] v);
    if (MSB_FIRST != 0) return {v[DATA_SIZE-2:0], v[DATA_SIZE-1]};
    else                return {v[0], v[DATA_SIZE-1:1]};
  endfunction

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    sdo_d     = sdo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d   = in;
          sdo_d     = out_bit(in);
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          sclk_d    = 1'b0;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling toggle: either present the next bit or close the frame.
            sclk_d = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              cs_n_d    = 1'b1;
              sdo_d     = 1'b0;
              busy_d    = 1'b0;
              done_d    = 1'b1;
              bit_cnt_d = '0;
              state_d   = S_DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shreg_d   = advance(shreg_q);
              sdo_d     = out_bit(advance(shreg_q));
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cs_n      = cs_n_q;
  assign sclk      = sclk_q;
  assign sdo       = sdo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hack_reg_readout.sv
// tb_hack_reg_readout
//   Two instances: dut_a (CLK_DIV=2, MSB first) and dut_b (CLK_DIV=1, LSB
//   first). Expected serial bits are pushed to a queue per DUT when a frame
//   is requested and popped on every observed sclk rise.
module tb_hack_reg_readout;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] in_a = '0, in_b = '0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        busy_a, done_a, cs_n_a, sclk_a, sdo_a;
  logic        busy_b, done_b, cs_n_b, sclk_b, sdo_b;
  logic [1:0]  dbg_a, dbg_b;

  hack_reg_readout #(.DATA_SIZE(16), .CLK_DIV(2), .MSB_FIRST(1)) dut_a (
    .clock(clk), .reset(rst), .in(in_a), .start(start_a),
    .busy(busy_a), .done(done_a), .cs_n(cs_n_a), .sclk(sclk_a), .sdo(sdo_a),
    .dbg_state(dbg_a)
  );

  hack_reg_readout #(.DATA_SIZE(16), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
    .clock(clk), .reset(rst), .in(in_b), .start(start_b),
    .busy(busy_b), .done(done_b), .cs_n(cs_n_b), .sclk(sclk_b), .sdo(sdo_b),
    .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  logic [0:0] exp_b_q[$];
  int checks = 0;
  int failures = 0;

  int rise_a = 0, done_cnt_a = 0, low_run_a = 0, last_run_a = 0;
  int rise_b = 0, done_cnt_b = 0, low_run_b = 0, high_run_b = 0;
  logic prev_sclk_a = 1'b0, prev_cs_a = 1'b1;
  logic prev_sclk_b = 1'b0, prev_cs_b = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  task automatic push_b(input logic [15:0] v);
    for (int i = 0; i < 16; i++) exp_b_q.push_back(v[i]);
  endtask

  task automatic monitor();
    // dut_a
    if (!prev_sclk_a && sclk_a) begin
      rise_a++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL a_extra_rise observed=rise expected=no_rise");
      end
      if (exp_q.size() != 0) chk("a_bit", 32'(sdo_a), 32'(exp_q.pop_front()));
    end
    if (!cs_n_a) low_run_a++;
    else if (!prev_cs_a) begin
      last_run_a = low_run_a;
      low_run_a = 0;
    end
    if (done_a) begin
      done_cnt_a++;
      chk("a_done_at_cs_rise", {29'd0, prev_cs_a, cs_n_a, busy_a}, 32'b010);
    end
    // dut_b
    if (!prev_sclk_b && sclk_b) begin
      rise_b++;
      checks++;
      assert (exp_b_q.size() != 0) else begin
        failures++;
        $error("FAIL b_extra_rise observed=rise expected=no_rise");
      end
      if (exp_b_q.size() != 0) chk("b_bit", 32'(sdo_b), 32'(exp_b_q.pop_front()));
    end
    if (!cs_n_b) begin
      if (prev_cs_b && done_cnt_b > 0) chk("b_gap", high_run_b, 2);
      high_run_b = 0;
      low_run_b++;
    end else begin
      if (!prev_cs_b) chk("b_cs_low", low_run_b, 32);
      low_run_b = 0;
      high_run_b++;
    end
    if (done_b) begin
      done_cnt_b++;
      chk("b_done_at_cs_rise", {29'd0, prev_cs_b, cs_n_b, busy_b}, 32'b010);
    end
    prev_sclk_a = sclk_a; prev_cs_a = cs_n_a;
    prev_sclk_b = sclk_b; prev_cs_b = cs_n_b;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int d0;
    d0 = done_cnt_a;
    for (int i = 0; i < budget && done_cnt_a == d0; i++) tick();
    chk(tag, done_cnt_a - d0, 1);
    tick();
    chk({tag, "_pulse_end"}, {31'd0, done_a}, 0);
  endtask

  task automatic frame_a(input string tag, input logic [15:0] v);
    in_a = v;
    push_a(v);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk({tag, "_accept"}, {28'd0, cs_n_a, busy_a, sclk_a, sdo_a}, {28'd0, 1'b0, 1'b1, 1'b0, v[15]});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, d0;

    // reset from random input state
    in_a = 16'($urandom_range(0, 65535));
    in_b = 16'($urandom_range(0, 65535));
    start_a = 1'($urandom_range(0, 1));
    start_b = 1'($urandom_range(0, 1));
    rst = 1'b1;
    tick(); tick();
    chk("a_reset_outs", {27'd0, cs_n_a, sclk_a, sdo_a, busy_a, done_a}, 32'b10000);
    chk("b_reset_outs", {27'd0, cs_n_b, sclk_b, sdo_b, busy_b, done_b}, 32'b10000);
    chk("a_reset_state", 32'(dbg_a), 0);
    start_a = 1'b0; start_b = 1'b0;
    rst = 1'b0;
    tick();

    // basic frame
    base = rise_a;
    frame_a("f1", 16'hA5C3);
    wait_done_a("f1_done", 200);
    chk("f1_cs_low", last_run_a, 64);
    chk("f1_rises", rise_a - base, 16);
    chk("f1_queue_empty", exp_q.size(), 0);

    // input change and stray start mid-frame
    base = rise_a;
    d0 = done_cnt_a;
    frame_a("f2", 16'hA5C3);
    for (int i = 0; i < 9; i++) tick();
    in_a = 16'hFFFF;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a("f2_done", 200);
    chk("f2_cs_low", last_run_a, 64);
    for (int i = 0; i < 20; i++) tick();
    chk("f2_single_done", done_cnt_a - d0, 1);
    chk("f2_rises", rise_a - base, 16);
    chk("f2_idle_after", {31'd0, cs_n_a}, 1);

    // reset mid-frame after 5th rise
    base = rise_a;
    frame_a("f3", 16'hA5C3);
    for (int i = 0; i < 200 && rise_a < base + 5; i++) tick();
    chk("f3_five_rises", rise_a - base, 5);
    rst = 1'b1;
    tick();
    chk("f3_abort_outs", {28'd0, cs_n_a, busy_a, sclk_a, done_a}, 32'b1000);
    chk("f3_abort_state", 32'(dbg_a), 0);
    rst = 1'b0;
    exp_q.delete();
    d0 = done_cnt_a;
    for (int i = 0; i < 40; i++) tick();
    chk("f3_no_done", done_cnt_a - d0, 0);

    // full frame after abort
    base = rise_a;
    frame_a("f4", 16'h1234);
    wait_done_a("f4_done", 200);
    chk("f4_cs_low", last_run_a, 64);
    chk("f4_rises", rise_a - base, 16);
    chk("f4_queue_empty", exp_q.size(), 0);

    // dut_b: LSB first, CLK_DIV=1, start held for three frames
    in_b = 16'h0001;
    push_b(16'h0001); push_b(16'h0001); push_b(16'h0001);
    d0 = done_cnt_b;
    base = rise_b;
    start_b = 1'b1;
    for (int i = 0; i < 300 && done_cnt_b < d0 + 3; i++) tick();
    start_b = 1'b0;
    chk("b_three_frames", done_cnt_b - d0, 3);
    for (int i = 0; i < 10; i++) tick();
    chk("b_rises", rise_b - base, 48);
    chk("b_queue_empty", exp_b_q.size(), 0);
    chk("b_idle_after", {31'd0, cs_n_b}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
